video_awb_round_sat: RTL and testbench
======================================

Name: video_awb_round_sat

Overview:
- Downstream stage of the AWB 12x12 unsigned gain multipliers. Each multiplier outputs a 24-bit pixel×gain product.
- This block takes the three per-channel products (R, G, B) and converts each back to pixel width:
  - rounds off the gain fraction bits;
  - saturates to the pixel maximum.
- Output is a valid/ready video stream carrying start-of-frame and end-of-line sideband.
- Also counts clipped pixels per frame, for the AWB control loop.

Parameters:
- PROD_W, 24: width of one channel product.
- PIX_W, 10: output pixel width per channel.
- GAIN_FRAC, 8: fractional bits in the gain (4.8 format). Legal range 1..PROD_W-PIX_W.
- CNT_W, 16: width of the per-frame saturation counter.

Ports:
- ap_clk, in, 1: clock.
- ap_rst, in, 1: reset.
- s_valid, in, 1: input beat valid.
- s_ready, out, 1: block can accept the input beat.
- s_prod, in, 3*PROD_W: products, ch0 in LSBs ({B,G,R}).
- s_user, in, 1: start of frame (first pixel).
- s_last, in, 1: end of line.
- m_valid, out, 1: output beat valid.
- m_ready, in, 1: downstream accepts the output beat.
- m_data, out, 3*PIX_W: rounded, saturated pixels, same channel order as s_prod.
- m_user, out, 1: start of frame, delayed with its data.
- m_last, out, 1: end of line, delayed with its data.
- sat_count, out, CNT_W: clipped-pixel count of the previous completed frame.
- sat_count_vld, out, 1: one-cycle pulse when sat_count updates.

Behaviour:
- Clocking and reset:
  - Single clock ap_clk.
  - ap_rst is synchronous and active-high.
- Reset values: s_ready=0 during reset; m_valid=0, m_data=0, m_user=0, m_last=0, sat_count=0, sat_count_vld=0. Internal counter=0, seen_sof=0.
- Pipeline:
  - Two register stages with one global enable: en = ~m_valid | m_ready.
  - s_ready = en and not in reset. This is a combinational path from m_ready, which is accepted.
  - Latency is 2 cycles from input transfer to m_valid, with no stalls.
  - Throughput is 1 beat per cycle.
  - No beat is dropped or duplicated under any m_ready pattern, and beat order is preserved.
  - While en=0, all stage registers hold.
- Stage 1, per channel:
  - r = prod + 2^(GAIN_FRAC-1), computed at PROD_W+1 bits so there is no wrap.
  - q = r >> GAIN_FRAC.
  - Result is round-half-up.
  - Register q, the valid bit, user, last and a per-channel "q > 2^PIX_W-1" flag.
- Stage 2, per channel:
  - pix = flag ? 2^PIX_W-1 : q[PIX_W-1:0].
  - beat_sat = OR of the three channel flags.
  - Output registers hold pix for each channel, plus valid, user and last.
- Saturation counter: updated only on an output transfer (m_valid & m_ready).
  - Transfer with m_user=1 and seen_sof=1:
    - sat_count <= cnt;
    - sat_count_vld <= 1 for exactly one cycle;
    - cnt <= beat_sat of the current beat (restart).
  - Transfer with m_user=1 and seen_sof=0:
    - seen_sof <= 1;
    - cnt <= beat_sat;
    - no publish.
  - Any other transfer: cnt <= cnt + beat_sat, saturating at 2^CNT_W-1.
  - beat_sat is registered alongside the stage-2 data.
- Boundary conditions:
  - An all-ones product (0xFFFFFF) must produce the max pixel, with no rounding wrap.
  - A product exactly at 2^PIX_W after rounding saturates and counts.
  - A product one below the threshold does not count.
- Reset mid-stream:
  - All in-flight beats are discarded and m_valid drops on the cycle after ap_rst.
  - cnt and seen_sof are cleared, so the first SOF after reset publishes nothing.
- Sideband: s_user and s_last are passed through unchanged and aligned with their data. There is no frame or line length checking.

Decomposition:
- Package video_awb_pkg holds:
  - PROD_W, PIX_W, GAIN_FRAC and CNT_W defaults;
  - NUM_CH=3;
  - the PIX_MAX constant;
  - the channel-slice index helper.
- Sub-module video_awb_round_sat_ch: one channel's two-stage round/saturate datapath with enable, instantiated 3 times.
- The top level owns the handshake, sideband registers and the saturation counter.

Test Plan:
- Rounding: R prod 0x000180 -> 2. Prod 0x00017F -> 1. Prod 0x000080 -> 1. Prod 0x00007F -> 0. All with no saturation flag.
- Saturation edge: prod 0x03FF7F -> 1023, not counted. Prod 0x03FF80 -> 1023, counted. Prod 0xFFFFFF -> 1023, counted.
- Backpressure: stream 10 beats with m_ready toggled on a 3-low/2-high pattern. Required: identical ordered output, s_ready low whenever m_valid=1 and m_ready=0, m_valid rising 2 cycles after the first transfer with m_ready held high.
- Frame count:
  - Frame 1 is 100 beats (user=1 on beat 0) with 7 beats containing at least one clipped channel, followed by a frame-2 SOF beat.
  - Required on the frame-2 SOF output transfer: sat_count=7 with a one-cycle sat_count_vld pulse.
  - Required at the first-ever SOF: no pulse.
- Reset mid-stream: assert ap_rst for 1 cycle while m_valid=1 and cnt=5. Required next cycle: m_valid=0, sat_count=0. The next SOF must give no sat_count_vld pulse.
- Counter ceiling, with CNT_W=4: a frame with 20 clipped beats, then an SOF, must give sat_count=15.

Source files
------------

// File: rtl/video_awb_pkg.sv
// video_awb_pkg: shared defaults, channel count and helpers for the AWB round/saturate stage
package video_awb_pkg;
  localparam int DEF_PROD_W = 24;
  localparam int DEF_PIX_W = 10;
  localparam int DEF_GAIN_FRAC = 8;
  localparam int DEF_CNT_W = 16;
  localparam int NUM_CH = 3;
  function automatic longint pix_max(input int w);
    return (longint'(1) << w) - 1;
  endfunction
  localparam int PIX_MAX = int'(pix_max(DEF_PIX_W));
  function automatic int ch_lo(input int c, input int w);
    return c * w;
  endfunction
endpackage

// File: rtl/video_awb_round_sat_ch.sv
// video_awb_round_sat_ch: one channel, stage 1 rounds half-up, stage 2 clamps to pixel max
module video_awb_round_sat_ch
  import video_awb_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int PIX_W = DEF_PIX_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [PROD_W-1:0] prod_i,
  output logic              sat_o,
  output logic [PIX_W-1:0]  pix_o
);
  localparam logic [PROD_W:0] HALF = (PROD_W+1)'(1) << (GAIN_FRAC - 1);
  localparam logic [PIX_W-1:0] MAX = PIX_W'(pix_max(PIX_W));
  logic [PROD_W:0] r, q;
  logic [PIX_W-1:0] q_q, pix_q, pix_d;
  logic sat_q;
  // one extra bit keeps an all-ones product from wrapping when rounded
  always_comb begin
    r = {1'b0, prod_i} + HALF;
    q = r >> GAIN_FRAC;
    pix_d = sat_q ? MAX : q_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
      sat_q <= 1'b0;
      pix_q <= '0;
    end else if (en) begin
      q_q <= q[PIX_W-1:0];
      sat_q <= |q[PROD_W:PIX_W];
      pix_q <= pix_d;
    end
  end
  assign sat_o = sat_q;
  assign pix_o = pix_q;
endmodule

// File: rtl/video_awb_round_sat.sv
// video_awb_round_sat: 3-channel round/saturate stream stage with per-frame clipped-pixel count
module video_awb_round_sat
  import video_awb_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int PIX_W = DEF_PIX_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NUM_CH*PROD_W-1:0] s_prod,
  input  logic                     s_user,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [NUM_CH*PIX_W-1:0]  m_data,
  output logic                     m_user,
  output logic                     m_last,
  output logic [CNT_W-1:0]         sat_count,
  output logic                     sat_count_vld
);
  logic en, xfer, sof;
  logic [NUM_CH-1:0] sat1;
  logic v1_q, u1_q, l1_q, mv_q, mu_q, ml_q, bs_q;
  logic seen_q, seen_d, scv_q, scv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, sc_q, sc_d;
  assign en = ~mv_q | m_ready;
  assign s_ready = en & ~ap_rst;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    video_awb_round_sat_ch #(.PROD_W(PROD_W), .PIX_W(PIX_W), .GAIN_FRAC(GAIN_FRAC)) u_ch (
      .clk(ap_clk),
      .rst(ap_rst),
      .en(en),
      .prod_i(s_prod[ch_lo(c, PROD_W) +: PROD_W]),
      .sat_o(sat1[c]),
      .pix_o(m_data[ch_lo(c, PIX_W) +: PIX_W])
    );
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      {v1_q, u1_q, l1_q, mv_q, mu_q, ml_q, bs_q} <= '0;
    end else if (en) begin
      {v1_q, u1_q, l1_q} <= {s_valid, s_user, s_last};
      {mv_q, mu_q, ml_q} <= {v1_q, u1_q, l1_q};
      bs_q <= |sat1;
    end
  end
  // an SOF restarts the count with its own clip; only SOFs after the first publish
  always_comb begin
    xfer = mv_q & m_ready;
    sof = xfer & mu_q;
    cnt_d = !xfer ? cnt_q : mu_q ? CNT_W'(bs_q) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(bs_q));
    seen_d = seen_q | sof;
    scv_d = sof & seen_q;
    sc_d = scv_d ? cnt_q : sc_q;
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt_q <= '0;
      sc_q <= '0;
      seen_q <= 1'b0;
      scv_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sc_q <= sc_d;
      seen_q <= seen_d;
      scv_q <= scv_d;
    end
  end
  assign m_valid = mv_q;
  assign m_user = mu_q;
  assign m_last = ml_q;
  assign sat_count = sc_q;
  assign sat_count_vld = scv_q;
endmodule

// File: tb/tb_video_awb_round_sat.sv
// tb_video_awb_round_sat: directed vectors checked against a queue-based behavioural model
module tb_video_awb_round_sat;
  logic ap_clk = 0, ap_rst = 1, s_valid = 0, s_user = 0, s_last = 0, m_ready;
  logic [71:0] s_prod = '0;
  logic s_ready, m_valid, m_user, m_last, sat_count_vld;
  logic [29:0] m_data;
  logic [15:0] sat_count;
  logic s_ready4, m_valid4, m_user4, m_last4, sat_count_vld4;
  logic [29:0] m_data4;
  logic [3:0] sat_count4;
  video_awb_round_sat dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .s_valid(s_valid), .s_ready(s_ready), .s_prod(s_prod),
    .s_user(s_user), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_user(m_user), .m_last(m_last), .sat_count(sat_count), .sat_count_vld(sat_count_vld)
  );
  video_awb_round_sat #(.CNT_W(4)) dut4 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .s_valid(s_valid), .s_ready(s_ready4), .s_prod(s_prod),
    .s_user(s_user), .s_last(s_last), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
    .m_user(m_user4), .m_last(m_last4), .sat_count(sat_count4), .sat_count_vld(sat_count_vld4)
  );
  always #5 ap_clk = ~ap_clk;
  typedef struct {logic [29:0] d; bit u, l, s;} beat_t;
  beat_t exq[$];
  logic [29:0] out_log[$];
  int n_chk = 0, n_fail = 0, mode = 0;
  int mcnt = 0, mcnt4 = 0, mseen = 0, exp_sc = 0, exp_sc4 = 0, exp_vld = 0;
  int pulses = 0, last_sc = 0, last_sc4 = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, x, $time);
    end
  endtask
  function automatic longint rnd(input logic [23:0] p);
    return (longint'(p) + 128) / 256;
  endfunction
  function automatic logic [9:0] epix(input logic [23:0] p);
    longint r = rnd(p);
    return (r > 1023) ? 10'd1023 : 10'(r);
  endfunction
  function automatic bit esat(input logic [23:0] p);
    return rnd(p) > 1023;
  endfunction
  initial begin
    m_ready = 1;
    forever begin
      int ph = 0;
      @(posedge ap_clk);
      #1;
      if (mode == 0) m_ready = 1;
      else if (mode == 2) m_ready = 0;
      else begin
        m_ready = ph >= 3;
        ph = (ph + 1) % 5;
      end
    end
  end
  always @(negedge ap_clk) begin
    beat_t e;
    chk("sat_count", 64'(sat_count), 64'(exp_sc));
    chk("sat_vld", 64'(sat_count_vld), 64'(exp_vld));
    chk("sat_count4", 64'(sat_count4), 64'(exp_sc4));
    chk("sat_vld4", 64'(sat_count_vld4), 64'(exp_vld));
    chk("twin", {m_valid4, m_data4, m_user4, m_last4, s_ready4}, {m_valid, m_data, m_user, m_last, s_ready});
    if (sat_count_vld) begin
      pulses++;
      last_sc = int'(sat_count);
      last_sc4 = int'(sat_count4);
    end
    if (m_valid && !m_ready) chk("s_ready_stall", 64'(s_ready), 0);
    if (ap_rst) begin
      exq.delete();
      {mcnt, mcnt4, mseen, exp_sc, exp_sc4, exp_vld} = '0;
    end else begin
      exp_vld = 0;
      if (m_valid && m_ready) begin
        if (exq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_beat: got %0h want none at %0t", m_data, $time);
        end else begin
          e = exq.pop_front();
          chk("m_data", 64'(m_data), 64'(e.d));
          chk("m_user", 64'(m_user), 64'(e.u));
          chk("m_last", 64'(m_last), 64'(e.l));
          out_log.push_back(m_data);
          if (e.u) begin
            if (mseen != 0) begin
              exp_sc = mcnt;
              exp_sc4 = mcnt4;
              exp_vld = 1;
            end
            mseen = 1;
            mcnt = int'(e.s);
            mcnt4 = int'(e.s);
          end else begin
            mcnt = (mcnt + int'(e.s) > 65535) ? 65535 : mcnt + int'(e.s);
            mcnt4 = (mcnt4 + int'(e.s) > 15) ? 15 : mcnt4 + int'(e.s);
          end
        end
      end
      if (s_valid && s_ready) begin
        e.d = {epix(s_prod[71:48]), epix(s_prod[47:24]), epix(s_prod[23:0])};
        e.s = esat(s_prod[71:48]) | esat(s_prod[47:24]) | esat(s_prod[23:0]);
        e.u = s_user;
        e.l = s_last;
        exq.push_back(e);
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask
  task automatic send(input logic [23:0] r, g, b, input bit u, l);
    bit ok = 0;
    int n = 0;
    s_prod = {b, g, r};
    s_user = u;
    s_last = l;
    s_valid = 1;
    while (!ok && n < 200) begin
      @(negedge ap_clk);
      ok = s_ready;
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    s_valid = 0;
  endtask
  task automatic clip_beat(input bit u, l);
    logic [23:0] p = 24'h03FF80 + 24'($urandom_range(0, 24'hBF0000));
    send(24'($urandom_range(0, 24'h03FF7F)), p, 24'($urandom_range(0, 24'h03FF7F)), u, l);
  endtask
  initial begin
    int p0, n;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_s_ready", 64'(s_ready), 0);
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_m_data", 64'(m_data), 0);
    chk("rst_flags", {m_user, m_last, sat_count_vld}, 0);
    chk("rst_sat_count", 64'(sat_count), 0);
    @(posedge ap_clk);
    #1;
    ap_rst = 0;
    idle(2);
    send(24'h000180, 24'h00017F, 24'h000080, 1, 0);
    @(negedge ap_clk);
    chk("lat_cycle1", 64'(m_valid), 0);
    @(negedge ap_clk);
    chk("lat_cycle2", 64'(m_valid), 1);
    idle(3);
    chk("first_sof_no_pulse", 64'(pulses), 0);
    send(24'h00007F, 24'h03FF7F, 24'h000000, 0, 0);
    send(24'h03FF80, 24'h000000, 24'h000000, 0, 0);
    send(24'h000000, 24'h000000, 24'hFFFFFF, 0, 1);
    send(24'h000000, 24'h000000, 24'h000000, 1, 0);
    idle(5);
    chk("round_vec", 64'(out_log[0]), {34'd0, 10'd1, 10'd1, 10'd2});
    chk("edge_below", 64'(out_log[1]), {34'd0, 10'd0, 10'd1023, 10'd0});
    chk("edge_at", 64'(out_log[2]), {34'd0, 10'd0, 10'd0, 10'd1023});
    chk("all_ones", 64'(out_log[3]), {34'd0, 10'd1023, 10'd0, 10'd0});
    chk("edge_pulse", 64'(pulses), 1);
    chk("edge_count", 64'(last_sc), 2);
    p0 = pulses;
    for (int i = 0; i < 100; i++) begin
      if (i inside {3, 10, 25, 40, 41, 77, 99}) clip_beat(i == 0, 0);
      else send(24'($urandom_range(0, 24'h03FF7F)), 24'($urandom_range(0, 24'h03FF7F)),
                24'($urandom_range(0, 24'h03FF7F)), i == 0, (i % 20) == 19);
    end
    send(24'h000100, 24'h000100, 24'h000100, 1, 0);
    idle(5);
    chk("frame_pulses", 64'(pulses - p0), 2);
    chk("frame_count", 64'(last_sc), 7);
    mode = 1;
    p0 = out_log.size();
    for (int i = 0; i < 10; i++)
      send(24'($urandom_range(0, 24'h040400)), 24'($urandom_range(0, 24'h040400)),
           24'($urandom_range(0, 24'h040400)), i == 0, i == 9);
    idle(30);
    chk("bp_beats", 64'(out_log.size() - p0), 10);
    mode = 0;
    idle(2);
    send(24'h000010, 24'h000010, 24'h000010, 1, 0);
    for (int i = 0; i < 5; i++) clip_beat(0, 0);
    idle(4);
    chk("model_cnt5", 64'(mcnt), 5);
    mode = 2;
    idle(2);
    send(24'h000200, 24'h000300, 24'h000400, 0, 0);
    n = 0;
    while (!m_valid && n < 20) begin
      idle(1);
      n++;
    end
    chk("mv_before_rst", 64'(m_valid), 1);
    ap_rst = 1;
    idle(1);
    ap_rst = 0;
    mode = 0;
    @(negedge ap_clk);
    chk("mid_rst_m_valid", 64'(m_valid), 0);
    chk("mid_rst_sat_count", 64'(sat_count), 0);
    idle(1);
    p0 = pulses;
    send(24'h000010, 24'h000010, 24'h000010, 1, 0);
    idle(4);
    chk("post_rst_sof_no_pulse", 64'(pulses - p0), 0);
    clip_beat(0, 0);
    clip_beat(0, 1);
    send(24'h000010, 24'h000010, 24'h000010, 1, 0);
    idle(5);
    chk("post_rst_pulse", 64'(pulses - p0), 1);
    chk("post_rst_count", 64'(last_sc), 2);
    for (int i = 0; i < 20; i++) clip_beat(0, 0);
    send(24'h000010, 24'h000010, 24'h000010, 1, 0);
    idle(5);
    chk("ceil_count16", 64'(last_sc), 20);
    chk("ceil_count4", 64'(last_sc4), 15);
    idle(5);
    chk("drained", 64'(exq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
